// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial sequencer driving a 1-bit ALU slice.
// Latches two WIDTH-bit operands and an opcode, then feeds the slice one bit
// per clock, LSB first. The slice carry is fed back as the next bit's carry-in,
// and the slice y bits are shifted into the result from the top.
// State table:
//   IDLE | waiting for start; result/carry_out hold the last answer
//   RUN  | WIDTH cycles of bit-serial processing, busy=1
//   DONE | one-cycle done pulse, start ignored
// Optional build macro ALU_SERIAL_OVF_EN adds a signed-overflow output.
module alu_serial_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_cin,
    output logic [2:0]       alu_sel,
    input  logic             alu_y,
    input  logic             alu_cout
`ifdef ALU_SERIAL_OVF_EN
    ,
    output logic             overflow
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0]       OP_ADD   = 3'b000;
    localparam logic [2:0]       OP_SUB   = 3'b001;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             is_arith;
`ifdef ALU_SERIAL_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    // Only ADD and SUB produce a meaningful final carry.
    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: latched opcode, operand shifters, bit counter, carry, result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= 3'b000;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            op_q     <= op_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            result_q <= result_d;
            carry_q  <= carry_d;
`ifdef ALU_SERIAL_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Next-state, datapath updates and slice drive.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        result_d = result_q;
        carry_d  = carry_q;
`ifdef ALU_SERIAL_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        busy     = 1'b0;
        done     = 1'b0;
        alu_a    = 1'b0;
        alu_b    = 1'b0;
        alu_cin  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    sh_a_d  = opa;
                    sh_b_d  = opb;
                    cnt_d   = '0;
                    // SUB is a + ~b + 1; the preset carry supplies the +1.
                    c_d     = (op == OP_SUB);
`ifdef ALU_SERIAL_OVF_EN
                    a_msb_d = opa[WIDTH-1];
                    b_msb_d = opb[WIDTH-1];
`endif
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                busy     = 1'b1;
                alu_a    = sh_a_q[0];
                alu_b    = sh_b_q[0];
                alu_cin  = c_q;
                result_d = {alu_y, result_q[WIDTH-1:1]};
                c_d      = alu_cout;
                sh_a_d   = {1'b0, sh_a_q[WIDTH-1:1]};
                sh_b_d   = {1'b0, sh_b_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    carry_d = is_arith ? alu_cout : 1'b0;
`ifdef ALU_SERIAL_OVF_EN
                    // alu_y here is the result MSB.
                    if (op_q == OP_ADD) begin
                        ovf_d = (a_msb_q == b_msb_q) && (alu_y != a_msb_q);
                    end else if (op_q == OP_SUB) begin
                        ovf_d = (a_msb_q != b_msb_q) && (alu_y != a_msb_q);
                    end else begin
                        ovf_d = 1'b0;
                    end
`endif
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign alu_sel   = op_q;
    assign result    = result_q;
    assign carry_out = carry_q;
`ifdef ALU_SERIAL_OVF_EN
    assign overflow  = ovf_q;
`endif

endmodule
